// File: rtl/pc_fetch_seq.sv
// Fetch address sequencer: BOOT/RUN/HALT, prioritised redirects, stall buffering.
// Optional redirect counter enabled by defining PC_REDIRECT_CNT_EN.
module pc_fetch_seq #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            nrst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  output logic [XLEN-1:0] pc_add_step,
  input  logic            branch_en,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            halt_req,
  output logic            halted,
  output logic            misalign
`ifdef PC_REDIRECT_CNT_EN
  ,
  output logic [31:0]     redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] LOW = XLEN'(INST_BYTES - 1);

  state_t          state;
  logic [XLEN-1:0] curr_pc;
  logic [XLEN-1:0] pend_addr;
  logic            pend_valid;
  logic            pend_is_trap;

  logic            fire;
  logic            in_run;
  logic            br_take;
  logic            redir;
  logic            apply;
  logic            latch;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] next_pc;

  assign req_addr    = curr_pc;
  assign pc_add_step = curr_pc + STEP;
  assign in_run      = (state == RUN);
  assign fire        = req_valid & req_ready;

  // A pending trap outranks any later branch, even a same-cycle one.
  assign br_take = branch_en & ~trap_en
                 & ~(pend_valid & pend_is_trap);
  assign redir   = trap_en | br_take;
  assign raw     = trap_en ? trap_addr : branch_addr;
  assign tgt     = raw & ~LOW;
  assign apply   = in_run ? fire : 1'b1;
  assign latch   = in_run & ~fire & redir;

  always_comb begin
    next_pc = curr_pc;
    priority case (1'b1)
      redir:      next_pc = tgt;
      pend_valid: next_pc = pend_addr;
      default:    next_pc = in_run ? pc_add_step
                                   : curr_pc;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= BOOT;
      req_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state     <= RUN;
          req_valid <= 1'b1;
        end
        RUN: begin
          if (fire && halt_req) begin
            state     <= HALT;
            req_valid <= 1'b0;
            halted    <= 1'b1;
          end
        end
        HALT: begin
          if (!halt_req) begin
            state     <= RUN;
            req_valid <= 1'b1;
            halted    <= 1'b0;
          end
        end
        default: begin
          state     <= BOOT;
          req_valid <= 1'b0;
          halted    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      curr_pc      <= RESET_VECTOR;
      pend_addr    <= '0;
      pend_valid   <= 1'b0;
      pend_is_trap <= 1'b0;
      misalign     <= 1'b0;
    end else begin
      misalign <= redir & |(raw & LOW);
      if (apply) begin
        curr_pc      <= next_pc;
        pend_valid   <= 1'b0;
        pend_is_trap <= 1'b0;
      end else if (latch) begin
        pend_addr    <= tgt;
        pend_valid   <= 1'b1;
        pend_is_trap <= trap_en;
      end
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  logic cnt_inc;
  assign cnt_inc = apply & (redir | pend_valid);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      redirect_cnt <= '0;
    end else if (cnt_inc && redirect_cnt != '1) begin
      redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: directed literal cases plus a randomized run
// compared every cycle against a queue-based reference model.
module tb_pc_fetch_seq;

  localparam logic [31:0] RV = 32'h0;
  localparam int IB = 4;

  logic        clk;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] pc_add_step;
  logic        branch_en;
  logic [31:0] branch_addr;
  logic        trap_en;
  logic [31:0] trap_addr;
  logic        halt_req;
  logic        halted;
  logic        misalign;
`ifdef PC_REDIRECT_CNT_EN
  logic [31:0] redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch_seq #(
    .XLEN(32),
    .RESET_VECTOR(RV),
    .INST_BYTES(IB)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .pc_add_step(pc_add_step),
    .branch_en(branch_en),
    .branch_addr(branch_addr),
    .trap_en(trap_en),
    .trap_addr(trap_addr),
    .halt_req(halt_req),
    .halted(halted),
    .misalign(misalign)
`ifdef PC_REDIRECT_CNT_EN
    ,
    .redirect_cnt(redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               name, act, exp);
    end
  endtask

  // Reference model: mode name, one-deep pending queue, plain arithmetic.
  typedef enum int {M_BOOT, M_RUN, M_HALT} mode_t;
  typedef struct {
    logic [31:0] addr;
    bit          trap;
  } pend_t;

  mode_t       m_mode = M_BOOT;
  logic [31:0] m_pc = RV;
  bit          m_mis = 0;
  longint      m_cnt = 0;
  pend_t       pq[$];

  always @(posedge clk or negedge nrst) begin
    bit          fire;
    bit          have;
    bit          apply;
    logic [31:0] t;
    if (!nrst) begin
      m_mode = M_BOOT;
      m_pc   = RV;
      m_mis  = 0;
      m_cnt  = 0;
      pq.delete();
    end else begin
      fire = (m_mode == M_RUN) && req_ready;
      have = 0;
      t    = 0;
      if (trap_en) begin
        have = 1;
        t    = trap_addr;
      end else if (branch_en &&
                   !(pq.size() > 0 && pq[0].trap)) begin
        have = 1;
        t    = branch_addr;
      end
      m_mis = have && (t % IB != 0);
      t     = t - (t % IB);
      apply = (m_mode != M_RUN) || fire;
      if (apply) begin
        if (have) begin
          m_pc = t;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end else if (pq.size() > 0) begin
          m_pc = pq[0].addr;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end else if (m_mode == M_RUN) begin
          m_pc = m_pc + IB;
        end
        pq.delete();
      end else if (have) begin
        pq.delete();
        pq.push_back('{t, trap_en});
      end
      case (m_mode)
        M_BOOT: m_mode = M_RUN;
        M_RUN:  if (fire && halt_req) m_mode = M_HALT;
        default: if (!halt_req) m_mode = M_RUN;
      endcase
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      chk("cmp_valid", 32'(req_valid),
          32'(m_mode == M_RUN));
      chk("cmp_halted", 32'(halted),
          32'(m_mode == M_HALT));
      chk("cmp_addr", req_addr, m_pc);
      chk("cmp_step", pc_add_step, m_pc + IB);
      chk("cmp_mis", 32'(misalign), 32'(m_mis));
`ifdef PC_REDIRECT_CNT_EN
      chk("cmp_cnt", redirect_cnt, 32'(m_cnt));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    branch_en   = 0;
    trap_en     = 0;
    branch_addr = 0;
    trap_addr   = 0;
  endtask

  initial begin
    logic [31:0] c0;
    nrst      = 0;
    req_ready = 0;
    halt_req  = 0;
    idle_in();
    c0 = 0;
    #12;
    chk("rst_valid", 32'(req_valid), 0);
    chk("rst_addr", req_addr, RV);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_mis", 32'(misalign), 0);
    @(negedge clk);
    nrst      = 1;
    req_ready = 1;
    #1;
    chk("boot_valid", 32'(req_valid), 0);
    cyc();
    chk("t1_valid", 32'(req_valid), 1);
    chk("t1_a0", req_addr, 32'h0);
    cyc();
    chk("t1_a4", req_addr, 32'h4);
    cyc();
    chk("t1_a8", req_addr, 32'h8);
    cyc();
    chk("t1_a12", req_addr, 32'hC);
    chk("t1_halted", 32'(halted), 0);

    // Test 2: pending branch held through a stall
    branch_en   = 1;
    branch_addr = 32'h100;
    cyc();
    chk("t2_pc100", req_addr, 32'h100);
    req_ready   = 0;
    branch_addr = 32'h200;
    cyc();
    idle_in();
    chk("t2_hold1", req_addr, 32'h100);
    cyc();
    chk("t2_hold2", req_addr, 32'h100);
    cyc();
    chk("t2_hold3", req_addr, 32'h100);
    chk("t2_vhold", 32'(req_valid), 1);
    req_ready = 1;
    cyc();
    chk("t2_tgt", req_addr, 32'h200);
    cyc();
    chk("t2_seq", req_addr, 32'h204);

    // Test 3: trap overrides pending branch, later branch loses
    req_ready   = 0;
    branch_en   = 1;
    branch_addr = 32'h300;
    cyc();
    idle_in();
    trap_en   = 1;
    trap_addr = 32'h80;
    cyc();
    idle_in();
    branch_en   = 1;
    branch_addr = 32'h400;
    cyc();
    idle_in();
    chk("t3_hold", req_addr, 32'h204);
    req_ready = 1;
    cyc();
    chk("t3_trap", req_addr, 32'h80);

    // Test 4: simultaneous trap and branch on fire
`ifdef PC_REDIRECT_CNT_EN
    c0 = redirect_cnt;
`endif
    trap_en     = 1;
    trap_addr   = 32'h80;
    branch_en   = 1;
    branch_addr = 32'h500;
    cyc();
    idle_in();
    chk("t4_prio", req_addr, 32'h80);
`ifdef PC_REDIRECT_CNT_EN
    chk("t4_cnt", redirect_cnt, c0 + 1);
`endif

    // Test 5: misaligned target
    branch_en   = 1;
    branch_addr = 32'h206;
    cyc();
    idle_in();
    chk("t5_align", req_addr, 32'h204);
    chk("t5_mis", 32'(misalign), 1);
    cyc();
    chk("t5_mis_off", 32'(misalign), 0);
    chk("t5_seq", req_addr, 32'h208);

    // Wrap of sequential increment
    branch_en   = 1;
    branch_addr = 32'hFFFF_FFFC;
    cyc();
    idle_in();
    chk("wrap_step", pc_add_step, 32'h0);
    cyc();
    chk("wrap_addr", req_addr, 32'h0);

    // Test 6: halt during stall, trap while halted, reset mid-stall
    req_ready = 0;
    halt_req  = 1;
    cyc();
    chk("t6_vstall", 32'(req_valid), 1);
    chk("t6_nohalt", 32'(halted), 0);
    req_ready = 1;
    cyc();
    chk("t6_halted", 32'(halted), 1);
    chk("t6_vlow", 32'(req_valid), 0);
    trap_en   = 1;
    trap_addr = 32'h80;
    cyc();
    idle_in();
    chk("t6_hpc", req_addr, 32'h80);
    halt_req = 0;
    cyc();
    chk("t6_resume_v", 32'(req_valid), 1);
    chk("t6_resume_a", req_addr, 32'h80);
    req_ready = 0;
    cyc();
    nrst = 0;
    #1;
    chk("t6_rst_v", 32'(req_valid), 0);
    chk("t6_rst_a", req_addr, RV);
    @(negedge clk);
    nrst = 1;

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      cyc();
      req_ready = ($urandom_range(0, 9) < 7);
      branch_en = ($urandom_range(0, 3) == 0);
      trap_en   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0)
        halt_req = ~halt_req;
      branch_addr = $urandom_range(0, 1) ?
        $urandom() : ($urandom() & 32'hFFC);
      trap_addr = $urandom_range(0, 3) == 0 ?
        $urandom() : 32'h80;
      if ($urandom_range(0, 199) == 0) begin
        nrst = 0;
        #1;
        chk("rnd_rst_v", 32'(req_valid), 0);
        chk("rnd_rst_a", req_addr, RV);
        @(negedge clk);
        nrst = 1;
      end
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
- Parametrised successor to the single-cycle PC register.
- Generates fetch addresses for the instruction fetch stage over a valid/ready request handshake.
- Arbitrates trap and branch redirects by fixed priority and buffers a redirect that arrives while a request is stalled.
- Adds BOOT/RUN/HALT sequencing; sits between the datapath redirect logic and the instruction memory/cache request port.

Parameters:
- XLEN, 32: address width in bits.
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset, XLEN bits.
- INST_BYTES, 4: sequential step and alignment granule. Must be a power of 2, ≥2.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset. Asynchronous assert, active-low.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  fetch port accepts request.
- req_addr  out  XLEN  fetch address; equals curr_pc.
- pc_add_step  out  XLEN  curr_pc + INST_BYTES, combinational, wraps mod 2^XLEN.
- branch_en  in  1  branch/jump redirect this cycle.
- branch_addr  in  XLEN  branch target.
- trap_en  in  1  trap/exception redirect this cycle.
- trap_addr  in  XLEN  trap vector target.
- halt_req  in  1  level; request fetch halt.
- halted  out  1  high while in HALT.
- misalign  out  1  one-cycle pulse: an accepted redirect target had nonzero low bits.

Behaviour:
Reset (nrst low, asynchronous):
- state=BOOT, curr_pc=RESET_VECTOR.
- pend_valid=0, pend_addr=0, misalign=0, halted=0, req_valid=0.
- Asserting nrst mid-handshake aborts the request; no pending state survives.

Definitions:
- fire = req_valid & req_ready.
- Redirect target = trap_addr if trap_en, else branch_addr. trap_en has priority over branch_en when both are high.
- Every redirect target is aligned before use: low log2(INST_BYTES) bits forced to 0. If any cleared bit was 1, misalign pulses high the next cycle.

States:
- BOOT:
  - req_valid=0 for exactly one cycle after nrst deasserts, then → RUN.
  - Redirects in BOOT update curr_pc directly.
- RUN:
  - req_valid=1; req_addr stays stable while req_valid & !req_ready.
  - Redirect with no fire: latch target into pend_addr, set pend_valid. A trap overwrites an existing pending entry; a branch does not overwrite a pending trap (pend_is_trap bit tracked).
  - On fire, curr_pc <= first of: same-cycle redirect target, pend_addr if pend_valid, pc_add_step. pend_valid is cleared on fire.
  - A same-cycle redirect beats pend_addr. Exception: a same-cycle branch loses to a pending trap.
  - halt_req=1 with fire: → HALT after the curr_pc update. Without fire: stay in RUN until fire.
- HALT:
  - req_valid=0, halted=1.
  - Redirects (after pending is merged) update curr_pc directly each cycle; pend_valid=0.
  - halt_req=0 → RUN next cycle, first request at curr_pc.

Latency: redirect on a fire cycle → target on req_addr next cycle; no bubble.

Arithmetic: sequential increment wraps, e.g. 32'hFFFF_FFFC+4 → 0. No flag raised.

Optional Feature:
- Macro PC_REDIRECT_CNT_EN.
- Defined:
  - Adds output redirect_cnt [31:0].
  - Counts redirects applied to curr_pc: on fire in RUN, or in HALT/BOOT. A pending redirect counts once, when applied. A latched redirect overwritten before being applied is not counted.
  - Saturates at 32'hFFFF_FFFF; reset to 0.
- Undefined: no port, no counter logic. All other behaviour identical.

Test Plan:
1. Reset, then req_ready=1 constant → req_valid=0 one cycle. req_addr sequence: RESET_VECTOR, +4, +8, +12. halted=0, misalign=0.
2. curr_pc=0x100, req_ready=0 for 3 cycles, branch_en=1 with 0x200 in cycle 1 only, then req_ready=1 → req_addr holds 0x100 until fire, then 0x200, then 0x204.
3. Stalled, pending branch 0x300; next cycle trap_en=1 with 0x80; then branch 0x400 while still stalled; then fire → next req_addr 0x80.
4. Fire cycle with trap_en=1 (0x80) and branch_en=1 (0x500) together → next req_addr 0x80. With PC_REDIRECT_CNT_EN, redirect_cnt increments by exactly 1.
5. branch_addr=0x00000206 on fire → next req_addr 0x204, misalign=1 for one cycle.
6. halt_req=1 during stall → req_valid stays 1 until fire, then halted=1, req_valid=0. Trap 0x80 while halted, then halt_req=0 → first request 0x80. nrst pulse mid-stall → req_valid=0, req_addr=RESET_VECTOR immediately.
